data_memory_responder: RTL and testbench

DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

---
 rtl/data_memory_responder.sv | 113 +++++++++++
 tb/tb_data_memory_responder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
// Single-port word memory behind a valid/ready request channel and a held response channel.
// Each access completes after WAIT_CYCLES wait states. Addresses at or above DEPTH return an error.
module data_memory_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      state, state_nxt;
    logic [2:0]  cnt, cnt_nxt;
    logic        lat_we;
    logic [31:0] lat_addr, lat_wdata;
    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;
    logic        err_q;

    logic        accept, enter_resp;
    logic        acc_we, acc_in_range;
    logic [31:0] acc_addr, acc_wdata;
    logic [AW-1:0] acc_idx;

    assign req_ready  = (state == S_IDLE);
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // With zero wait states the access happens on the accept edge itself,
    // so the request is taken straight from the inputs instead of the latches.
    assign acc_we       = (state == S_IDLE) ? req_we    : lat_we;
    assign acc_addr     = (state == S_IDLE) ? req_addr  : lat_addr;
    assign acc_wdata    = (state == S_IDLE) ? req_wdata : lat_wdata;
    assign acc_in_range = (acc_addr < 32'(DEPTH));
    assign acc_idx      = acc_addr[AW-1:0];

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        enter_resp = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nxt  = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = 3'(WAIT_CYCLES - 1);
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 3'd0) begin
                    state_nxt  = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end
            S_RESP: begin
                if (resp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= 3'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (enter_resp) begin
                rdata_q <= (!acc_we && acc_in_range) ? mem[acc_idx] : 32'd0;
                err_q   <= !acc_in_range;
            end else if (state == S_RESP && resp_ready) begin
                rdata_q <= 32'd0;
                err_q   <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
        end
    end

    // Memory is deliberately outside the reset domain; reset only blocks a pending write.
    always_ff @(posedge clk) begin
        if (!rst && enter_resp && acc_we && acc_in_range)
            mem[acc_idx] <= acc_wdata;
    end
endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: a one-wait-state instance driven by a vector table, hand sequences and random traffic,
// plus a zero-wait-state instance for the single-edge latency case.
module tb_data_memory_responder;
    localparam int W     = 1;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err;
    logic [31:0] req_addr, req_wdata, resp_rdata;
    logic        z_rst, z_req_valid, z_req_ready, z_req_we, z_resp_valid, z_resp_ready, z_resp_err;
    logic [31:0] z_req_addr, z_req_wdata, z_resp_rdata;

    data_memory_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err));

    data_memory_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(z_rst), .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata), .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
        .resp_rdata(z_resp_rdata), .resp_err(z_resp_err));

    int total = 0;
    int bad   = 0;
    logic [31:0] model [int];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          hold;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One transaction on the W-wait-state instance; the response is held for `hold` cycles
    // while garbage requests are presented, and must stay frozen.
    task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                       output logic [31:0] rdata, output logic err);
        int lat;
        @(negedge clk);
        chk("txn_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        resp_ready = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'(W));
        rdata = resp_rdata;
        err   = resp_err;
        chk("busy_ready", 32'(req_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1; req_we = 1'($urandom);
            req_addr = 32'($urandom_range(0, 15)); req_wdata = $urandom;
            @(posedge clk); @(negedge clk);
            chk("hold_valid", 32'(resp_valid), 32'd1);
            chk("hold_rdata", resp_rdata, rdata);
            chk("hold_err", 32'(resp_err), 32'(err));
            chk("hold_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("post_valid", 32'(resp_valid), 32'd0);
        chk("post_rdata", resp_rdata, 32'd0);
        chk("post_err", 32'(resp_err), 32'd0);
        chk("post_ready", 32'(req_ready), 32'd1);
        resp_ready = 1'b0;
    endtask

    task automatic model_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input int hold);
        logic [31:0] r;
        logic        e;
        logic        oor;
        oor = (addr >= 32'(DEPTH));
        txn(we, addr, wdata, hold, r, e);
        chk("rnd_err", 32'(e), 32'(oor));
        if (we || oor) chk("rnd_rdata_zero", r, 32'd0);
        else if (model.exists(int'(addr))) chk("rnd_rdata", r, model[int'(addr)]);
        if (we && !oor) model[int'(addr)] = wdata;
    endtask

    // Zero-wait instance: response must be visible right after the accept edge.
    task automatic z_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata, output logic [31:0] rdata);
        @(negedge clk);
        z_req_valid = 1'b1; z_req_we = we; z_req_addr = addr; z_req_wdata = wdata; z_resp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        z_req_valid = 1'b0;
        chk("z_valid", 32'(z_resp_valid), 32'd1);
        chk("z_err", 32'(z_resp_err), 32'd0);
        rdata = z_resp_rdata;
        @(posedge clk); @(negedge clk);
        chk("z_release", 32'(z_resp_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] r;
        logic        e;
        logic [31:0] b2b_data;
        int          acc_cyc [2];
        int          nacc;
        logic        got_seen;
        logic [31:0] got;

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        z_rst = 1'b1; z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_resp_ready = 1'b0;

        tbl[0]  = '{1'b1, 32'd5,          32'hDEADBEEF, 32'd0,        1'b0, 0};
        tbl[1]  = '{1'b0, 32'd5,          32'd0,        32'hDEADBEEF, 1'b0, 5};
        tbl[2]  = '{1'b0, 32'd1024,       32'd0,        32'd0,        1'b1, 0};
        tbl[3]  = '{1'b1, 32'd0,          32'h11111111, 32'd0,        1'b0, 0};
        tbl[4]  = '{1'b1, 32'h0000_0400,  32'h99999999, 32'd0,        1'b1, 0};
        tbl[5]  = '{1'b0, 32'd0,          32'd0,        32'h11111111, 1'b0, 0};
        tbl[6]  = '{1'b0, 32'hFFFF_FFFF,  32'd0,        32'd0,        1'b1, 1};
        tbl[7]  = '{1'b1, 32'h8000_0005,  32'h00000055, 32'd0,        1'b1, 0};
        tbl[8]  = '{1'b0, 32'd5,          32'd0,        32'hDEADBEEF, 1'b0, 0};
        tbl[9]  = '{1'b1, 32'd1023,       32'hCAFEF00D, 32'd0,        1'b0, 0};
        tbl[10] = '{1'b0, 32'd1023,       32'd0,        32'hCAFEF00D, 1'b0, 2};
        tbl[11] = '{1'b1, 32'd7,          32'h0000AAAA, 32'd0,        1'b0, 0};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_err", 32'(resp_err), 32'd0);
        rst = 1'b0; z_rst = 1'b0;
        chk("rst_ready", 32'(req_ready), 32'd1);

        foreach (tbl[i]) begin
            txn(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].hold, r, e);
            chk($sformatf("vec%0d_rdata", i), r, tbl[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), 32'(e), 32'(tbl[i].exp_err));
            if (tbl[i].we && !tbl[i].exp_err) model[int'(tbl[i].addr)] = tbl[i].wdata;
        end

        // Store to 7 aborted by reset on the edge that would enter RESP.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'd7; req_wdata = 32'h1234; resp_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        req_valid = 1'b0; rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        chk("abort_valid", 32'(resp_valid), 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            chk("abort_no_resp", 32'(resp_valid), 32'd0);
        end
        resp_ready = 1'b0;
        txn(1'b0, 32'd7, 32'd0, 0, r, e);
        chk("abort_mem_kept", r, 32'h0000AAAA);

        // Reset while a response is pending clears it.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'd5; resp_ready = 1'b0;
        repeat (W + 1) @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("resp_pending", 32'(resp_valid), 32'd1);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_ready", 32'(req_ready), 32'd1);

        // Back-to-back with req_valid held: store 3 then load 3.
        b2b_data = 32'h0BADF00D;
        nacc = 0; got_seen = 1'b0; got = '0;
        acc_cyc[0] = 0; acc_cyc[1] = 0;
        @(negedge clk);
        resp_ready = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_addr = 32'd3; req_wdata = b2b_data;
        for (int c = 0; c < 30 && !(nacc == 2 && got_seen); c++) begin
            if (nacc == 1 && req_we) begin
                req_we = 1'b0; req_wdata = 32'd0;
            end
            if (nacc == 2) req_valid = 1'b0;
            if (resp_valid && nacc == 2) begin
                got = resp_rdata; got_seen = 1'b1;
            end
            if (req_valid && req_ready && nacc < 2) begin
                acc_cyc[nacc] = c; nacc++;
            end
            @(posedge clk); @(negedge clk);
        end
        req_valid = 1'b0; resp_ready = 1'b0;
        chk("b2b_accepts", 32'(nacc), 32'd2);
        chk("b2b_spacing", 32'(acc_cyc[1] - acc_cyc[0]), 32'(W + 2));
        chk("b2b_seen", 32'(got_seen), 32'd1);
        chk("b2b_rdata", got, b2b_data);
        model[3] = b2b_data;

        for (int n = 0; n < 150; n++) begin
            logic [31:0] a;
            case ($urandom_range(0, 3))
                0, 1, 2: a = 32'($urandom_range(0, 31));
                default: case ($urandom_range(0, 3))
                    0: a = 32'd1023;
                    1: a = 32'd1024;
                    2: a = 32'd1025;
                    default: a = $urandom | 32'h0000_0400;
                endcase
            endcase
            model_txn(1'($urandom), a, $urandom, ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0);
        end

        // Zero-wait build, including reset colliding with the RESP-entry edge.
        z_txn(1'b1, 32'd9, 32'h5555, r);
        chk("z_store_rdata", r, 32'd0);
        z_txn(1'b0, 32'd9, 32'd0, r);
        chk("z_load_rdata", r, 32'h5555);
        @(negedge clk);
        z_req_valid = 1'b1; z_req_we = 1'b1; z_req_addr = 32'd9; z_req_wdata = 32'h7777; z_rst = 1'b1;
        @(posedge clk); @(negedge clk);
        z_rst = 1'b0; z_req_valid = 1'b0;
        chk("z_rst_valid", 32'(z_resp_valid), 32'd0);
        chk("z_rst_ready", 32'(z_req_ready), 32'd1);
        z_txn(1'b0, 32'd9, 32'd0, r);
        chk("z_rst_nowrite", r, 32'h5555);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
